multisim_server_chan: RTL and testbench
=======================================

# multisim_server_chan

Buffered stream channel endpoint for the multisim server side. It carries one ready/valid data stream between local RTL and the inter-simulation link. The thin wrappers multisim_server_push (RTL→link) and multisim_server_pull (link→RTL) each instantiate it once. AXI server adapters use one wrapper per AXI channel (AW, W, AR push; B, R pull).

## Interface
- DATA_WIDTH, 32: payload width in bits, at least 1.
- DEPTH, 4: buffer entries; power of two, at least 2.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- in_data  in  DATA_WIDTH  producer payload.
- in_vld  in  1  producer valid.
- in_rdy  out  1  buffer can accept.
- out_data  out  DATA_WIDTH  head-of-buffer payload.
- out_vld  out  1  buffer holds at least one entry.
- out_rdy  in  1  consumer ready.
- level  out  $clog2(DEPTH)+1  current occupancy.
- in_cnt  out  32  accepted-beat counter; wraps.
- out_cnt  out  32  delivered-beat counter; wraps.

Wrapper mapping:
- Push: data/data_vld/data_rdy map to in_*. The link drains out_*.
- Pull: the link fills in_*. data/data_vld/data_rdy map to out_*.

## Operation
- Circular FIFO with wr_ptr, rd_ptr and count registers.
- Write beat: in_vld && in_rdy. Stores in_data at wr_ptr, wr_ptr+1 mod DEPTH, in_cnt+1.
- Read beat: out_vld && out_rdy. rd_ptr+1 mod DEPTH, out_cnt+1.
- count changes by +1 on write only, -1 on read only, and stays the same when both occur.
- in_rdy = !rst && (count != DEPTH).
- out_vld = !rst && (count != 0).
- out_data = mem[rd_ptr]. The value is don't-care when out_vld=0.
- level = count.
- No pass-through: an empty buffer never presents same-cycle input at the output.
- Full with a simultaneous read: in_rdy is still 0 that cycle; the freed slot becomes visible the next cycle.
- Empty: out_vld=0, and out_rdy is ignored.
- Pointers wrap naturally at DEPTH. in_cnt and out_cnt wrap 0xFFFFFFFF→0.
- Stream order is strictly FIFO; no beat is dropped or duplicated.
- The buffer enforces no producer-side hold rules.
- Reset:
  - Outputs while rst=1: in_rdy=0, out_vld=0, level=0, in_cnt=0, out_cnt=0.
  - rst clears pointers, count and counters immediately (asynchronously).
  - mem is not reset.
  - Reset mid-stream discards all buffered beats.

## Timing
- Latency from write beat at edge N to out_vld=1 is 1 cycle: visible after edge N.
- Throughput is 1 beat/cycle in steady state, with simultaneous read and write.
- in_rdy, out_vld and level depend only on registers and rst; there is no combinational path from in_vld or out_rdy.
- On rst deassertion, in_rdy rises in the same cycle, so the first write is possible at the next edge.

## Structure
- Package multisim_pkg holds:
  - typedef enum {MULTISIM_PUSH, MULTISIM_PULL} multisim_dir_e, used by the wrappers.
  - localparam CNT_W = 32.
- One natural sub-module, multisim_fifo: the storage plus pointer/count logic. The top level adds the reset gating of in_rdy and out_vld, plus the beat counters.
- multisim_server_push and multisim_server_pull are port-renaming wrappers only.

## Test plan
All cases use DATA_WIDTH=8, DEPTH=4.
- Reset: hold rst=1 with in_vld=1 and in_data=0xAA → in_rdy=0, out_vld=0, level=0; nothing is stored after release.
- Fill: out_rdy=0, write 0x11, 0x22, 0x33, 0x44 on consecutive cycles → level=4, in_rdy=0, out_data=0x11. A 5th beat 0x55 held with in_vld=1 is not accepted.
- Drain order: from full, set out_rdy=1 → reads 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles, then out_vld=0 and out_cnt=4.
- Streaming: in_vld=1 and out_rdy=1 for 10 cycles with data 0..9 → out_vld rises 1 cycle after the first write, level stays 1, and outputs arrive in order 0..9.
- Full plus simultaneous read: at level=4 with in_vld=1 and out_rdy=1 → that cycle delivers 1 beat and accepts none, then level=3 and in_rdy=1.
- Reset mid-operation: at level=2, pulse rst asynchronously between edges → out_vld, level and counters go to 0 immediately. The next write 0x77 is read back as 0x77.

Source files
------------

// File: rtl/multisim_pkg.sv
// multisim_pkg: shared types and constants for the multisim server channel endpoints.
package multisim_pkg;
    typedef enum logic {MULTISIM_PUSH, MULTISIM_PULL} multisim_dir_e;
    localparam int CNT_W = 32;
endpackage

// File: rtl/multisim_fifo.sv
// multisim_fifo: circular buffer storage with read/write pointers and occupancy count.
module multisim_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end
    assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/multisim_server_pull.sv
// multisim_server_pull: link-to-RTL endpoint; the buffer output drives the local stream.
module multisim_server_pull
    import multisim_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   link_data,
    input  logic                    link_vld,
    output logic                    link_rdy,
    output logic [DATA_WIDTH-1:0]   data,
    output logic                    data_vld,
    input  logic                    data_rdy,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_W-1:0]        in_cnt,
    output logic [CNT_W-1:0]        out_cnt
);
    multisim_server_chan #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_chan (
        .clk      (clk),
        .rst      (rst),
        .in_data  (link_data),
        .in_vld   (link_vld),
        .in_rdy   (link_rdy),
        .out_data (data),
        .out_vld  (data_vld),
        .out_rdy  (data_rdy),
        .level    (level),
        .in_cnt   (in_cnt),
        .out_cnt  (out_cnt)
    );
endmodule

// File: rtl/multisim_server_push.sv
// multisim_server_push: RTL-to-link endpoint; local stream feeds the buffer input.
module multisim_server_push
    import multisim_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic                    data_vld,
    output logic                    data_rdy,
    output logic [DATA_WIDTH-1:0]   link_data,
    output logic                    link_vld,
    input  logic                    link_rdy,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_W-1:0]        in_cnt,
    output logic [CNT_W-1:0]        out_cnt
);
    multisim_server_chan #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_chan (
        .clk      (clk),
        .rst      (rst),
        .in_data  (data),
        .in_vld   (data_vld),
        .in_rdy   (data_rdy),
        .out_data (link_data),
        .out_vld  (link_vld),
        .out_rdy  (link_rdy),
        .level    (level),
        .in_cnt   (in_cnt),
        .out_cnt  (out_cnt)
    );
endmodule

// File: rtl/multisim_server_chan.sv
// multisim_server_chan: buffered ready/valid channel endpoint with beat counters.
module multisim_server_chan
    import multisim_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_vld,
    output logic                    in_rdy,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [$clog2(DEPTH):0]  level,
    output logic [CNT_W-1:0]        in_cnt,
    output logic [CNT_W-1:0]        out_cnt
);
    localparam int LW = $clog2(DEPTH) + 1;
    logic [LW-1:0] count;
    logic wr_en;
    logic rd_en;
    // Handshake flags come only from registered count and rst, never from in_vld/out_rdy.
    assign in_rdy  = !rst && (count != LW'(DEPTH));
    assign out_vld = !rst && (count != '0);
    assign wr_en   = in_vld && in_rdy;
    assign rd_en   = out_vld && out_rdy;
    assign level   = count;
    multisim_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_data (out_data),
        .count   (count)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (wr_en) in_cnt <= in_cnt + CNT_W'(1);
            if (rd_en) out_cnt <= out_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_multisim_server_chan.sv
// tb_multisim_server_chan: scenario tasks checked against a queue-based model of the channel.
module tb_multisim_server_chan;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_vld;
    logic        in_rdy;
    logic [7:0]  out_data;
    logic        out_vld;
    logic        out_rdy;
    logic [2:0]  level;
    logic [31:0] in_cnt;
    logic [31:0] out_cnt;

    int errors = 0;
    int checks = 0;
    logic [7:0]  q[$];
    logic [31:0] ic = 0;
    logic [31:0] oc = 0;

    always #5 clk = ~clk;

    multisim_server_chan #(.DATA_WIDTH(8), .DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .out_data (out_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .level    (level),
        .in_cnt   (in_cnt),
        .out_cnt  (out_cnt)
    );

    // Advance one clock (negedge to negedge) and apply the channel rules to the model.
    task automatic cycle();
        logic w, r;
        logic [7:0] d;
        w = in_vld && !rst && q.size() < 4;
        r = out_rdy && !rst && q.size() > 0;
        d = in_data;
        @(posedge clk);
        if (rst) begin
            q.delete();
            ic = 0;
            oc = 0;
        end else begin
            if (r) begin
                void'(q.pop_front());
                oc = oc + 1;
            end
            if (w) begin
                q.push_back(d);
                ic = ic + 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_vld = 1'b1; in_data = 8'hAA; out_rdy = 1'b0;
        repeat (3) cycle();
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL reset_in_rdy got=%b exp=0", in_rdy); end
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got=%b exp=0", out_vld); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (in_cnt !== 32'd0 || out_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnts got=%0d/%0d exp=0/0", in_cnt, out_cnt); end
        rst = 1'b0; in_vld = 1'b0;
        #1;
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL release_in_rdy got=%b exp=1", in_rdy); end
        cycle();
        checks++; if (out_vld !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL release_empty got vld=%b lvl=%0d exp vld=0 lvl=0", out_vld, level); end
    endtask

    task automatic test_fill();
        logic [31:0] ic0;
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_vld = 1'b1; in_data = 8'h11 * 8'(i + 1);
            cycle();
        end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level got=%0d exp=4", level); end
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL fill_in_rdy got=%b exp=0", in_rdy); end
        checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL fill_head got=%h exp=11", out_data); end
        ic0 = ic;
        in_data = 8'h55;
        repeat (2) cycle();
        checks++; if (level !== 3'd4 || in_cnt !== ic0) begin errors++; $display("FAIL fill_5th got lvl=%0d in_cnt=%0d exp lvl=4 in_cnt=%0d", level, in_cnt, ic0); end
        in_vld = 1'b0;
    endtask

    task automatic test_drain();
        in_vld = 1'b0; out_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_vld !== 1'b1 || out_data !== 8'h11 * 8'(i + 1)) begin
                errors++; $display("FAIL drain_%0d got vld=%b data=%h exp vld=1 data=%h", i, out_vld, out_data, 8'h11 * 8'(i + 1));
            end
            cycle();
        end
        checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", out_vld); end
        checks++; if (out_cnt !== 32'd4 || out_cnt !== oc) begin errors++; $display("FAIL drain_out_cnt got=%0d exp=4", out_cnt); end
    endtask

    task automatic test_stream();
        in_vld = 1'b1; out_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'(i);
            if (i == 0) begin
                checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL stream_no_passthru got=%b exp=0", out_vld); end
            end else begin
                checks++;
                if (out_vld !== 1'b1 || out_data !== 8'(i - 1) || level !== 3'd1) begin
                    errors++; $display("FAIL stream_%0d got vld=%b data=%h lvl=%0d exp vld=1 data=%h lvl=1", i, out_vld, out_data, level, 8'(i - 1));
                end
            end
            cycle();
        end
        checks++; if (out_data !== 8'd9 || level !== 3'd1) begin errors++; $display("FAIL stream_last got data=%h lvl=%0d exp data=09 lvl=1", out_data, level); end
        in_vld = 1'b0;
        cycle();
        checks++; if (level !== 3'd0 || out_cnt !== oc) begin errors++; $display("FAIL stream_end got lvl=%0d out_cnt=%0d exp lvl=0 out_cnt=%0d", level, out_cnt, oc); end
    endtask

    task automatic test_full_read();
        logic [31:0] ic0, oc0;
        out_rdy = 1'b0; in_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hA0 + 8'(i);
            cycle();
        end
        ic0 = in_cnt; oc0 = out_cnt;
        in_data = 8'h66; out_rdy = 1'b1;
        checks++; if (in_rdy !== 1'b0 || out_data !== 8'hA0) begin errors++; $display("FAIL fullrd_pre got rdy=%b data=%h exp rdy=0 data=a0", in_rdy, out_data); end
        cycle();
        checks++; if (level !== 3'd3 || in_rdy !== 1'b1) begin errors++; $display("FAIL fullrd_post got lvl=%0d rdy=%b exp lvl=3 rdy=1", level, in_rdy); end
        checks++; if (in_cnt !== ic0 || out_cnt !== oc0 + 32'd1) begin errors++; $display("FAIL fullrd_cnts got %0d/%0d exp %0d/%0d", in_cnt, out_cnt, ic0, oc0 + 32'd1); end
        in_vld = 1'b0;
        repeat (3) cycle();
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL fullrd_drain got=%0d exp=0", level); end
    endtask

    task automatic test_async_reset();
        out_rdy = 1'b0; in_vld = 1'b1;
        in_data = 8'h01; cycle();
        in_data = 8'h02; cycle();
        in_vld = 1'b0;
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL arst_pre got=%0d exp=2", level); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_vld !== 1'b0 || level !== 3'd0) begin errors++; $display("FAIL arst_now got vld=%b lvl=%0d exp vld=0 lvl=0", out_vld, level); end
        checks++; if (in_cnt !== 32'd0 || out_cnt !== 32'd0) begin errors++; $display("FAIL arst_cnts got %0d/%0d exp 0/0", in_cnt, out_cnt); end
        #1 rst = 1'b0;
        q.delete(); ic = 0; oc = 0;
        @(negedge clk);
        in_vld = 1'b1; in_data = 8'h77;
        cycle();
        in_vld = 1'b0; out_rdy = 1'b1;
        checks++; if (out_vld !== 1'b1 || out_data !== 8'h77 || level !== 3'd1) begin errors++; $display("FAIL arst_reuse got vld=%b data=%h lvl=%0d exp vld=1 data=77 lvl=1", out_vld, out_data, level); end
        cycle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_vld  = 1'($urandom_range(0, 1));
            out_rdy = ($urandom_range(0, 3) != 0) ? (i % 64 < 40) : 1'b0;
            in_data = 8'($urandom);
            checks++;
            if (in_rdy !== (q.size() != 4) || out_vld !== (q.size() != 0) || level !== 3'(q.size())) begin
                errors++; $display("FAIL rand_flags_%0d got rdy=%b vld=%b lvl=%0d exp lvl=%0d", i, in_rdy, out_vld, level, q.size());
            end
            if (q.size() != 0) begin
                checks++;
                if (out_data !== q[0]) begin errors++; $display("FAIL rand_data_%0d got=%h exp=%h", i, out_data, q[0]); end
            end
            checks++;
            if (in_cnt !== ic || out_cnt !== oc) begin errors++; $display("FAIL rand_cnts_%0d got %0d/%0d exp %0d/%0d", i, in_cnt, out_cnt, ic, oc); end
            cycle();
        end
    endtask

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_full_read();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
